// File: rtl/shift_rx_deser.sv
// Serial-to-parallel receiver for the shift_reg serial link.
// Detects a start bit, samples DATA_W data bits mid-bit, checks the stop bit
// and hands the word over on a valid/ready holding register.
// Optional feature: define RX_PARITY_EN to add an even-parity bit between the
// last data bit and the stop bit, plus a parity_err output pulse.
module shift_rx_deser #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          LSB_FIRST    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ser_in,
   output logic [DATA_W-1:0] par_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun,
`ifdef RX_PARITY_EN
   output logic              parity_err,
`endif
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
`ifdef RX_PARITY_EN
   localparam logic [2:0] ST_PARITY    = 3'd5;
`endif

   logic [2:0]        state, state_nxt;
   logic [CNT_W-1:0]  baud_cnt, baud_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_nxt;
   logic [DATA_W-1:0] shift, shift_nxt, shift_in;
   // One-cycle flags raised at the stop-bit sample; the output stage acts on
   // them one cycle later.
   logic              done_pend, done_nxt;
   logic              ferr_pend, ferr_nxt;
`ifdef RX_PARITY_EN
   // Running XOR of data bits and the parity bit; 1 at the end means odd.
   logic              parity_acc, parity_nxt;
`endif

   // Shift the current line sample into the word in the configured bit order.
   always_comb begin
      if (LSB_FIRST) begin
         shift_in             = shift >> 1;
         shift_in[DATA_W-1]   = ser_in;
      end else begin
         shift_in             = shift << 1;
         shift_in[0]          = ser_in;
      end
   end

   // Next-state logic for the frame FSM and its baud/bit counters.
   always_comb begin
      state_nxt  = state;
      baud_nxt   = baud_cnt;
      bit_nxt    = bit_cnt;
      shift_nxt  = shift;
      done_nxt   = 1'b0;
      ferr_nxt   = 1'b0;
`ifdef RX_PARITY_EN
      parity_nxt = parity_acc;
`endif
      case (state)
         ST_IDLE: begin
            if (!ser_in) begin
               state_nxt = ST_START;
               baud_nxt  = '0;
            end
         end
         ST_START: begin
            if (baud_cnt == BAUD_HALF) begin
               baud_nxt  = '0;
               bit_nxt   = '0;
`ifdef RX_PARITY_EN
               parity_nxt = 1'b0;
`endif
               // A high line at mid start bit is a glitch: drop it silently.
               state_nxt = ser_in ? ST_IDLE : ST_DATA;
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_nxt  = '0;
               shift_nxt = shift_in;
`ifdef RX_PARITY_EN
               parity_nxt = parity_acc ^ ser_in;
`endif
               if (bit_cnt == BIT_LAST) begin
                  bit_nxt = '0;
`ifdef RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
`ifdef RX_PARITY_EN
         ST_PARITY: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_nxt   = '0;
               parity_nxt = parity_acc ^ ser_in;
               state_nxt  = ST_STOP;
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_nxt = '0;
               if (ser_in) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = ST_WAIT_IDLE;
               end
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         ST_WAIT_IDLE: begin
            if (ser_in) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame FSM state, counters and receive shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         done_pend  <= 1'b0;
         ferr_pend  <= 1'b0;
`ifdef RX_PARITY_EN
         parity_acc <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         baud_cnt   <= baud_nxt;
         bit_cnt    <= bit_nxt;
         shift      <= shift_nxt;
         done_pend  <= done_nxt;
         ferr_pend  <= ferr_nxt;
`ifdef RX_PARITY_EN
         parity_acc <= parity_nxt;
`endif
      end
   end

   // Holding register with valid/ready handshake and the error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_out    <= '0;
         out_valid  <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err  <= ferr_pend;
         overrun    <= 1'b0;
`ifdef RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (done_pend) begin
            if (out_valid && !out_ready) begin
               // Unconsumed word wins; the new one is lost.
               overrun <= 1'b1;
            end else begin
               // Also covers a handshake in the same cycle: valid stays high.
               par_out   <= shift;
               out_valid <= 1'b1;
`ifdef RX_PARITY_EN
               parity_err <= parity_acc;
`endif
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_rx_deser.sv
// Directed bench for shift_rx_deser (DATA_W=8, CLKS_PER_BIT=4, LSB first).
// Expected words go into a scoreboard queue when a frame is driven and are
// compared when the DUT hands a word over. Honours RX_PARITY_EN if defined.
module tb_shift_rx_deser;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef RX_PARITY_EN
   localparam int LAT = 43;
`else
   localparam int LAT = 39;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ser_in;
   logic          out_ready;
   logic [DW-1:0] par_out;
   logic          out_valid;
   logic          frame_err;
   logic          overrun;
   logic          busy;
`ifdef RX_PARITY_EN
   logic          parity_err;
`endif

   always #5 clk = ~clk;

   shift_rx_deser #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB),
      .LSB_FIRST    (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ser_in     (ser_in),
      .par_out    (par_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
`ifdef RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] sb[$];

   int   rise_cyc = -1, ferr_cyc = -1, ovr_cyc = -1, perr_cyc = -1;
   int   rise_cnt = 0, valid_hi = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
   logic prev_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Output monitor: records pulses and scores handed-over words.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (out_valid) valid_hi++;
         if (out_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
         end
         if (frame_err) begin
            ferr_cnt++;
            ferr_cyc = cyc;
         end
         if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
         end
`ifdef RX_PARITY_EN
         if (parity_err) begin
            perr_cnt++;
            perr_cyc = cyc;
         end
`endif
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("word", 32'(par_out), 32'(sb.pop_front()));
         end
      end
      prev_valid = out_valid;
   end

   task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit,
                             input logic par_bit, input bit ready_last, output int t0);
      t0 = cyc + 1;
      ser_in = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < DW; i++) begin
         ser_in = d[i];
         repeat (CPB) tick();
      end
`ifdef RX_PARITY_EN
      ser_in = par_bit;
      repeat (CPB) tick();
`else
      if (par_bit === 1'bx) ser_in = 1'b1;
`endif
      ser_in = stop_bit;
      repeat (CPB - 1) tick();
      if (ready_last) out_ready = 1'b1;
      tick();
      ser_in = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, t1;
      int r0, f0, o0, v0;
      logic [DW-1:0] pats [4];
      pats[0] = 8'hA5; pats[1] = 8'hFF; pats[2] = 8'h01; pats[3] = 8'h80;

      // Reset held with the line low.
      rst = 1'b1; ser_in = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_par_out", 32'(par_out), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      ser_in = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      // Good frames, consumer always ready.
      out_ready = 1'b1;
      v0 = valid_hi;
      f0 = ferr_cnt;
      foreach (pats[k]) begin
         sb.push_back(pats[k]);
         send_frame(pats[k], 1'b1, ^pats[k], 1'b0, t0);
         tick();
         chk("rise_latency", 32'(rise_cyc), 32'(t0 + LAT));
      end
      chk("valid_one_cycle_each", 32'(valid_hi - v0), 32'd4);
      chk("good_no_ferr", 32'(ferr_cnt), 32'(f0));
      chk("good_sb_drained", 32'(sb.size()), 32'd0);

      // Start-bit glitch.
      r0 = rise_cnt;
      ser_in = 1'b0;
      tick();
      chk("glitch_busy", 32'(busy), 32'd1);
      ser_in = 1'b1;
      repeat (45) tick();
      chk("glitch_idle", 32'(busy), 32'd0);
      chk("glitch_no_valid", 32'(rise_cnt), 32'(r0));
      chk("glitch_no_ferr", 32'(ferr_cnt), 32'(f0));

      // Bad stop bit.
      send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, t0);
      chk("ferr_wait_idle_busy", 32'(busy), 32'd1);
      chk("ferr_no_valid", 32'(out_valid), 32'd0);
      tick();
      chk("ferr_cycle", 32'(ferr_cyc), 32'(t0 + LAT));
      chk("ferr_count", 32'(ferr_cnt), 32'(f0 + 1));
      tick();
      chk("ferr_back_idle", 32'(busy), 32'd0);
      chk("ferr_no_rise", 32'(rise_cnt), 32'(r0));

      // Reset in the middle of a frame.
      f0 = ferr_cnt;
      ser_in = 1'b0;
      repeat (10) tick();
      ser_in = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_idle", 32'(busy), 32'd0);
      repeat (45) tick();
      chk("midrst_no_rise", 32'(rise_cnt), 32'(r0));
      chk("midrst_no_ferr", 32'(ferr_cnt), 32'(f0));

      // Overrun: two frames, consumer stalled.
      out_ready = 1'b0;
      o0 = ovr_cnt;
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1, ^8'h11, 1'b0, t0);
      send_frame(8'h22, 1'b1, ^8'h22, 1'b0, t1);
      tick();
      chk("ovr_cycle", 32'(ovr_cyc), 32'(t1 + LAT));
      chk("ovr_count", 32'(ovr_cnt), 32'(o0 + 1));
      chk("ovr_held_word", 32'(par_out), 32'h11);
      chk("ovr_held_valid", 32'(out_valid), 32'd1);
      chk("ovr_single_rise", 32'(rise_cnt), 32'(r0 + 1));
      out_ready = 1'b1;
      tick();
      tick();
      chk("ovr_drained_valid", 32'(out_valid), 32'd0);
      chk("ovr_sb_drained", 32'(sb.size()), 32'd0);

      // Word completes in the same cycle as a handshake.
      out_ready = 1'b0;
      o0 = ovr_cnt;
      sb.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, t0);
      sb.push_back(8'h96);
      send_frame(8'h96, 1'b1, ^8'h96, 1'b1, t0);
      tick();
      chk("same_cycle_no_ovr", 32'(ovr_cnt), 32'(o0));
      chk("same_cycle_valid_low", 32'(out_valid), 32'd0);
      chk("same_cycle_sb_drained", 32'(sb.size()), 32'd0);

`ifdef RX_PARITY_EN
      // Parity error: word still delivered with a parity_err pulse.
      out_ready = 1'b1;
      sb.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, t0);
      tick();
      chk("perr_count", 32'(perr_cnt), 32'd1);
      chk("perr_cycle", 32'(perr_cyc), 32'(t0 + LAT));
      chk("perr_rise", 32'(rise_cyc), 32'(t0 + LAT));
      chk("perr_sb_drained", 32'(sb.size()), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
